// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial divider: FSM state encoding and default width.
package serial_divider_pkg;

  localparam int unsigned DIV_XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/serial_divider_rca.sv
// Plain ripple-carry adder; the divider drives it as a subtractor (inverted b, carry_in=1).
module ripple_carry_adder #(
  parameter int unsigned xlen = 32
) (
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            carry_in,
  output logic [xlen-1:0] sum,
  output logic            carry_out
);

  logic c;

  always_comb begin
    sum = '0;
    c   = carry_in;
    for (int unsigned i = 0; i < xlen; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry_out = c;
  end

endmodule

// File: rtl/serial_divider.sv
// Restoring serial divider with RISC-V DIV/DIVU/REM/REMU semantics, one quotient bit per clock.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int unsigned xlen = DIV_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_signed,
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [xlen-1:0] quotient,
  output logic [xlen-1:0] remainder,
  output logic            div_by_zero
);

  localparam int unsigned CW = (xlen > 1) ? $clog2(xlen) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(xlen - 1);
  localparam logic [xlen-1:0] INT_MIN = {1'b1, {(xlen-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [xlen-1:0] dvd_q, dvd_d;
  logic [xlen-1:0] dvs_q, dvs_d;
  logic [xlen:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [xlen-1:0] quo_q, quo_d;
  logic [xlen-1:0] rmd_q, rmd_d;
  logic            dbz_q, dbz_d;

  logic [xlen:0]   shifted, diff, sub_b;
  logic            no_borrow;

  function automatic logic [xlen-1:0] negate(input logic [xlen-1:0] x);
    return (~x) + xlen'(1);
  endfunction

  assign shifted = (rem_q << 1) | {{xlen{1'b0}}, dvd_q[xlen-1]};
  assign sub_b   = ~{1'b0, dvs_q};

  ripple_carry_adder #(.xlen(xlen + 1)) u_sub (
    .a         (shifted),
    .b         (sub_b),
    .carry_in  (1'b1),
    .sum       (diff),
    .carry_out (no_borrow)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = (is_signed && a[xlen-1]) ? negate(a) : a;
          dvs_d   = (is_signed && b[xlen-1]) ? negate(b) : b;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = is_signed & (a[xlen-1] ^ b[xlen-1]);
          neg_r_d = is_signed & a[xlen-1];
          if (b == '0) begin
            quo_d   = '1;
            rmd_d   = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (is_signed && (a == INT_MIN) && (b == '1)) begin
            quo_d   = a;
            rmd_d   = '0;
            dbz_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = no_borrow ? diff : shifted;
        dvd_d = {dvd_q[xlen-2:0], no_borrow};
        cnt_d = cnt_q + CW'(1);
        // Final step: sign-correct from this cycle's next values, not the stale registers.
        if (cnt_q == LAST_ITER) begin
          quo_d   = neg_q_q ? negate(dvd_d) : dvd_d;
          rmd_d   = neg_r_q ? negate(rem_d[xlen-1:0]) : rem_d[xlen-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider at xlen=32.
module tb_serial_divider;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  serial_divider #(.xlen(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for out_valid; lat=999 on timeout.
  task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        output int lat);
    bit seen;
    @(negedge clk);
    is_signed = sgn; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0001; is_signed = ~sgn;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) lat = 999;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_divu_basic();
    int lat;
    run_op(1'b0, 32'd100, 32'd7, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL divu_latency: got %0d want 32", lat); end
    n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL divu_q: got %h want %h", quotient, 32'd14); end
    n_cmp++; if (remainder !== 32'd2) begin n_bad++; $display("FAIL divu_r: got %h want %h", remainder, 32'd2); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL divu_dbz: got %b want 0", div_by_zero); end
    consume();
  endtask

  task automatic test_signed_div();
    int lat;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL div_neg_latency: got %0d want 32", lat); end
    n_cmp++; if (quotient !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_q: got %h want fffffffd", quotient); end
    n_cmp++; if (remainder !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_r: got %h want ffffffff", remainder); end
    consume();
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    n_cmp++; if (quotient !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_negb_q: got %h want fffffffd", quotient); end
    n_cmp++; if (remainder !== 32'd1) begin n_bad++; $display("FAIL div_negb_r: got %h want 1", remainder); end
    consume();
  endtask

  task automatic test_div_by_zero();
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 32'd5, 32'd0, lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dbz_latency(s=%0d): got %0d want 1", s, lat); end
      n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_q(s=%0d): got %h want ffffffff", s, quotient); end
      n_cmp++; if (remainder !== 32'd5) begin n_bad++; $display("FAIL dbz_r(s=%0d): got %h want 5", s, remainder); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_flag(s=%0d): got %b want 1", s, div_by_zero); end
      consume();
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ovf_latency: got %0d want 1", lat); end
    n_cmp++; if (quotient !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_q: got %h want 80000000", quotient); end
    n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL ovf_r: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
    consume();
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL ovfu_latency: got %0d want 32", lat); end
    n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL ovfu_q: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'h8000_0000) begin n_bad++; $display("FAIL ovfu_r: got %h want 80000000", remainder); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(1'b0, 32'hFFFF_FFFF, 32'd3, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL bp_latency: got %0d want 32", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (quotient !== 32'h5555_5555) begin n_bad++; $display("FAIL bp_q[%0d]: got %h want 55555555", i, quotient); end
      n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL bp_r[%0d]: got %h want 0", i, remainder); end
    end
    consume();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_hold: got %b want 1", in_ready); end
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge clk);
    is_signed = 1'b0; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL areset_q: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL areset_r: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL areset_dbz: got %b want 0", div_by_zero); end
    @(negedge clk);
    rstn = 1'b1;
    run_op(1'b0, 32'd9, 32'd3, lat);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL post_reset_latency: got %0d want 32", lat); end
    n_cmp++; if (quotient !== 32'd3) begin n_bad++; $display("FAIL post_reset_q: got %h want 3", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL post_reset_r: got %h want 0", remainder); end
    consume();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed_div();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
